// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns a shared 4:1 one-bit mux.
// It grants one requester at a time, caps how long one owner may hold the mux, and drives the mux selects.
module mux_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic       out
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state_reg, state_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;
  logic       valid_reg, valid_next;

  logic [3:0] masked;
  logic       found;
  logic [1:0] win;
  logic [3:0] data;

  assign data = {d, c, b, a};

  // The current owner never competes in its own handoff search.
  assign masked = (state_reg == GRANT) ? (req & ~(4'b0001 << ptr_reg)) : req;

  // The scan starts at ptr+1 and wraps. The loop runs downward, so the closest set bit is assigned last and wins.
  always_comb begin
    found = 1'b0;
    win   = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (masked[ptr_reg + 2'(k + 1)]) begin
        found = 1'b1;
        win   = ptr_reg + 2'(k + 1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 2'd3;
      cnt_reg   <= 4'd0;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'b00;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    valid_next = valid_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          ptr_next   = win;
          cnt_next   = 4'd1;
          gnt_next   = 4'b0001 << win;
          sel_next   = win;
          valid_next = 1'b1;
        end
      end
      GRANT: begin
        if (!req[ptr_reg] || (cnt_reg == HOLD_LIM && found)) begin
          if (found) begin
            ptr_next = win;
            cnt_next = 4'd1;
            gnt_next = 4'b0001 << win;
            sel_next = win;
          end else begin
            // The selects keep their last value while the arbiter is idle.
            state_next = IDLE;
            cnt_next   = 4'd0;
            gnt_next   = 4'b0000;
            valid_next = 1'b0;
          end
        end else if (cnt_reg < HOLD_LIM) begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt   = gnt_reg;
    s1    = sel_reg[1];
    s0    = sel_reg[0];
    valid = valid_reg;
    out   = valid_reg ? data[sel_reg] : 1'b0;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, scoreboard-checked bench for mux_rr_arbiter with HOLD_MAX = 4.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] data_v;
  logic [3:0] gnt;
  logic       s1, s0, valid, out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    string      tag;
  } exp_t;

  exp_t sb[$];

  mux_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a(data_v[0]), .b(data_v[1]), .c(data_v[2]), .d(data_v[3]),
    .gnt(gnt), .s1(s1), .s0(s0), .valid(valid), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag, input logic [1:0] es, input logic ev);
    logic exp_out;
    exp_out = ev ? data_v[es] : 1'b0;
    checks++;
    assert (out === exp_out) else begin
      errors++;
      $error("FAIL %s out got %b exp %b", tag, out, exp_out);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    checks++;
    assert (gnt === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt got %b exp %b", e.tag, gnt, e.gnt);
    end
    checks++;
    assert ({s1, s0} === e.sel) else begin
      errors++;
      $error("FAIL %s sel got %b exp %b", e.tag, {s1, s0}, e.sel);
    end
    checks++;
    assert (valid === e.valid) else begin
      errors++;
      $error("FAIL %s valid got %b exp %b", e.tag, valid, e.valid);
    end
    check_out(e.tag, e.sel, e.valid);
    $display("%s: req=%b gnt=%b sel=%b valid=%b out=%b", e.tag, req, gnt, {s1, s0}, valid, out);
  endtask

  // Drive one cycle of stimulus, queue what should appear after the next edge, then compare.
  task automatic cycle(input logic [3:0] r, input logic [3:0] dat, input logic [3:0] eg,
                       input logic [1:0] es, input logic ev, input string tag);
    exp_t e;
    req    = r;
    data_v = dat;
    e.gnt = eg; e.sel = es; e.valid = ev; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    rst    = 1'b1;
    req    = 4'b1111;
    data_v = 4'b1111;

    // Reset is held with every requester active.
    cycle(4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, "reset0");
    cycle(4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, "reset1");
    rst = 1'b0;

    // Fairness: four cycles per owner in the order 0,1,2,3,0.
    for (int i = 0; i < 20; i++) begin
      logic [1:0] o;
      o = 2'((i / 4) % 4);
      cycle(4'b1111, 4'($urandom_range(0, 15)), 4'b0001 << o, o, 1'b1, $sformatf("fair%0d", i));
    end

    // The owner releases and no one else is waiting, so the selects stay at 00.
    cycle(4'b0000, 4'b1111, 4'b0000, 2'b00, 1'b0, "idle_after_fair");

    // Single requester c: the output follows c combinationally.
    cycle(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, "single_c");
    data_v = 4'b1011;
    #1;
    check_out("c_toggle_low", 2'b10, 1'b1);
    for (int i = 0; i < 10; i++)
      cycle(4'b0100, 4'($urandom_range(0, 15)), 4'b0100, 2'b10, 1'b1, $sformatf("hold_c%0d", i));

    // Handoff without an idle cycle, from owner 1 to owner 3.
    cycle(4'b0000, 4'b0000, 4'b0000, 2'b10, 1'b0, "idle2");
    cycle(4'b0010, 4'b0010, 4'b0010, 2'b01, 1'b1, "grant_b");
    cycle(4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1, "handoff_d");
    cycle(4'b0000, 4'b1000, 4'b0000, 2'b11, 1'b0, "idle_keep_11");

    // Wrap-around: after owner 3 the search starts again at requester 0.
    cycle(4'b1001, 4'b0001, 4'b0001, 2'b00, 1'b1, "wrap_a");
    cycle(4'b1000, 4'b1000, 4'b1000, 2'b11, 1'b1, "wrap_back_d");

    // Mid-grant reset while c owns the mux with cnt=2.
    cycle(4'b0000, 4'b0000, 4'b0000, 2'b11, 1'b0, "idle3");
    cycle(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, "c_cnt1");
    cycle(4'b0100, 4'b0100, 4'b0100, 2'b10, 1'b1, "c_cnt2");
    rst = 1'b1;
    cycle(4'b1111, 4'b1111, 4'b0000, 2'b00, 1'b0, "mid_reset");
    rst = 1'b0;
    cycle(4'b1111, 4'b1111, 4'b0001, 2'b00, 1'b1, "post_reset_a");

    // Preemption during a partial request: owner 0 reaches the hold limit and b takes over.
    cycle(4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b1, "pre_a2");
    cycle(4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b1, "pre_a3");
    cycle(4'b0011, 4'b0011, 4'b0001, 2'b00, 1'b1, "pre_a4");
    cycle(4'b0011, 4'b0010, 4'b0010, 2'b01, 1'b1, "preempt_b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for the shared 4:1 one-bit mux (inputs a, b, c, d; selects s1, s0). Four requesters compete for the mux. The block grants exactly one at a time, drives s1/s0 for the granted input, and presents the selected bit on out. A hold limit stops any requester from monopolising the resource.

## Interface
Parameters:
- HOLD_MAX, default 4: maximum consecutive cycles one owner keeps the grant while others wait. Legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request vector; bit i = requester i (0→a, 1→b, 2→c, 3→d)
- a, b, c, d  input  1 each  mux data inputs
- gnt  output  4  one-hot grant, registered; 0000 when idle
- s1, s0  output  1 each  registered mux select: a=00, b=01, c=10, d=11
- valid  output  1  registered; high while a grant is active
- out  output  1  combinational: the selected input (per s1/s0) when valid=1, else 0

## Operation
- Reset values: state IDLE, gnt=0000, s1=0, s0=0, valid=0, out=0, hold counter cnt=0, round-robin pointer ptr=3 (the first search starts at requester 0).
- The round-robin search is a scan of req starting at index (ptr+1) mod 4 and wrapping upward. The first asserted bit wins.
- IDLE:
  - If req=0000, stay in IDLE.
  - Otherwise grant the search winner and go to GRANT. Set ptr to the winner, cnt=1, gnt to the one-hot code of the winner, {s1,s0} to the winner index, valid=1.
- GRANT, owner o = ptr:
  - Release: req[o]=0. Run the search over req with bit o masked.
    - If there is a winner, hand off to it on the same edge, with no idle bubble. Set cnt=1 and ptr to the winner.
    - If there is no winner, go to IDLE with gnt=0000 and valid=0. s1/s0 keep their last value.
  - Preempt: req[o]=1, cnt==HOLD_MAX, and any other req bit set. Hand off to the search winner with bit o masked; set cnt=1 and ptr to the winner.
  - Continue: req[o]=1 and no release or preempt. Keep the grant; cnt increments and saturates at HOLD_MAX.
- gnt is always one-hot or zero. valid equals the OR of gnt. {s1,s0} always encodes the set gnt bit when valid=1.
- Requests are level-sensitive; the arbiter holds no request memory. A requester that drops req before it is granted loses its turn.

## Timing
- Grant latency: req sampled at edge N → gnt, s1/s0 and valid update after edge N. The first valid cycle is N+1.
- out is combinational from the registered selects. It tracks changes in a/b/c/d within the same cycle and has no latency beyond select.
- Handoff on release or preempt: the old owner's gnt falls and the new owner's gnt rises on the same edge. valid stays 1 throughout.
- Round-robin with all four requesting continuously gives the order 0,1,2,3,0,…, with each grant lasting exactly HOLD_MAX cycles.
- If HOLD_MAX=1 and all four request, the grant rotates every cycle.
- Simultaneous release and new request from the same index at the same edge is treated as release: bit o is masked in that cycle's search.
- Reset mid-grant: on the edge where rst=1, all registers return to reset values, including ptr=3.
- rst has priority over all other inputs.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=1111 → gnt=0000, valid=0, s1s0=00, out=0. Release rst with req=1111 → gnt=0001 after the next edge.
- Single requester: req=0100, c=1, others 0 → one edge later gnt=0100, s1s0=10, out=1. Toggle c to 0 → out=0 in the same cycle. Hold req for 10 cycles → grant stays; cnt saturates at 4 with no rotation.
- Fairness: HOLD_MAX=4, req=1111 continuously for 20 cycles → gnt sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001×4. valid is 1 throughout and s1s0 follows 00,01,10,11,00.
- No-bubble handoff: owner 1 (gnt=0010) drops req while req[3]=1 → next edge gnt=1000, s1s0=11, valid stays 1. Then req=0000 → gnt=0000, valid=0, s1s0 stays 11.
- Wrap-around: ptr=3 (last owner d), req=1001 → grant goes to 0. Then req[0] drops → grant goes to 3.
- Mid-operation reset: during gnt=0100 with cnt=2, pulse rst for 1 cycle with req=1111 → that edge yields gnt=0000 and valid=0. The following edge yields gnt=0001.
